// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a preloadable word-addressed
// instruction memory. It fetches the word at pc, presents it to the CPU
// with a one-cycle newinstr pulse, waits for instrDone, then advances pc
// sequentially or by a signed word offset when a branch is taken.
// Optional feature: define FETCH_HALT_EN to stop fetching (HALT state) when
// the fetched word is 32'hFFFF_FFFF; a later start restarts from PC_RESET.
module instr_fetch #(
  parameter int          IMEM_WORDS = 128,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          loadEn,
  input  logic [$clog2(IMEM_WORDS)-1:0] loadAddr,
  input  logic [31:0]                   loadData,
  input  logic                          instrDone,
  input  logic                          branchTaken,
  input  logic [15:0]                   branchOffset,
  output logic [31:0]                   instrword,
  output logic                          newinstr,
  output logic [31:0]                   pc,
  output logic                          busy,
  output logic                          halted
);

  localparam int AW = $clog2(IMEM_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3
`ifdef FETCH_HALT_EN
    , HALT = 3'd4
`endif
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   imem [IMEM_WORDS];
  logic [31:0]   mem_word;
  logic [AW-1:0] fetch_idx;
  logic [31:0]   branch_disp;
  logic [31:0]   pc_next;
  logic          mem_we;

  // Only the low pc bits select a word, so fetch addresses wrap around the memory.
  assign fetch_idx   = pc[AW+1:2];
  assign mem_word    = imem[fetch_idx];

  // Word offset sign-extended to 32 bits and scaled to a byte displacement.
  assign branch_disp = {{14{branchOffset[15]}}, branchOffset, 2'b00};

  // Next-state, next-pc and preload-enable decode; memory writes are only legal while not fetching.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        mem_we = loadEn;
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
`ifdef FETCH_HALT_EN
        if (mem_word == 32'hFFFF_FFFF) begin
          state_next = HALT;
        end else begin
          state_next = ISSUE;
        end
`else
        state_next = ISSUE;
`endif
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (instrDone) begin
          state_next = FETCH;
          pc_next    = pc + 32'd4 + (branchTaken ? branch_disp : 32'd0);
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        mem_we = loadEn;
        if (start) begin
          state_next = FETCH;
          pc_next    = PC_RESET;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, pc and instruction registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= PC_RESET;
      instrword <= 32'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH) begin
        instrword <= mem_word;
      end
    end
  end

  // Instruction memory preload port; contents survive reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      imem[loadAddr] <= loadData;
    end
  end

  assign newinstr = (state == ISSUE);
  assign busy     = (state == FETCH) || (state == ISSUE) || (state == WAIT);

`ifdef FETCH_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
